y86_fetch_sequencer: RTL and testbench
======================================

# y86_fetch_sequencer

Multi-cycle fetch controller for the byte-wide Y86-64 instruction memory. It steps the memory address one byte per cycle from the current PC. It assembles a complete instruction (icode/ifun, rA/rB, 64-bit valC), computes valP, and presents the result to decode with a valid/ready handshake. It sits between the PC logic and the decode stage, and owns the memory's address input.

## Interface
- MEM_BYTES, 128, instruction memory size in bytes; fetch addresses ≥ MEM_BYTES are address errors
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- run  in  1  permit fetching of a new instruction
- redirect  in  1  abort current fetch, restart at redirect_pc
- redirect_pc  in  64  new PC
- mem_addr  out  64  byte address to instruction memory
- mem_byte  in  8  memory data, combinational from mem_addr
- out_valid  out  1  assembled instruction available
- out_ready  in  1  decode accepts
- icode, ifun, rA, rB  out  4 each  instruction fields
- valC  out  64  constant, little-endian assembled
- valP  out  64  PC + instruction length
- pc_out  out  64  address of the instruction's first byte
- stat  out  2  00 AOK, 01 HLT, 10 ADR, 11 INS
- halted  out  1  sequencer stopped on a non-AOK instruction

## Operation
- States:
  - IDLE
  - OPC: capture icode/ifun
  - REG: capture rA/rB
  - CONST: 8 bytes, 3-bit counter k
  - DONE: output held
  - HALT
- mem_addr = pc + byte offset (OPC 0, REG 1, CONST 1+need_reg+k); in IDLE/DONE/HALT it equals pc.
- Length by icode:
  - 0 halt, 1 nop, 9 ret: 1 byte
  - 2 cmovXX, 6 OPq, A pushq, B popq: 2 bytes (regs)
  - 3, 4, 5: 10 bytes (regs + valC)
  - 7 jXX, 8 call: 9 bytes (valC, no reg byte; rA = rB = F)
  - icode > B: 1 byte, stat INS
- Unused fields read 0, except absent rA/rB, which read F.
- CONST byte k is written to valC[8k+7:8k].
- IDLE→OPC when run=1.
- OPC→REG, CONST or DONE per the length table.
- REG→CONST if valC is needed, else DONE.
- CONST→DONE after k=7.
- Address error: if a byte fetch address ≥ MEM_BYTES, stat=ADR and the state goes to DONE immediately. Fields captured so far are kept; valP = faulting address.
- DONE: out_valid=1. On out_ready:
  - pc ← valP.
  - If stat≠AOK, go to HALT (halted=1).
  - Otherwise go to OPC if run=1, else IDLE.
- HALT is left only by redirect or rst.
- redirect has priority in every state:
  - pc ← redirect_pc; fields are cleared; stat=AOK; halted=0.
  - Next state is OPC if run, else IDLE.
  - If redirect coincides with a DONE handshake, the handshake completes (decode consumed it) and pc takes redirect_pc.
- run=0 only gates leaving IDLE/DONE; an in-progress assembly finishes.
- valP/pc arithmetic is 64-bit modulo 2^64; wrap past 2^64−1 is not an error beyond the ADR check.

## Timing
- Reset (asynchronous, immediate):
  - state IDLE, pc=0, mem_addr=0, out_valid=0
  - all fields and valC/valP/pc_out 0
  - stat=AOK, halted=0
- One byte is captured per clock; mem_byte is sampled at the edge ending the cycle in which mem_addr is driven.
- If OPC is entered at cycle t, an L-byte instruction shows out_valid from cycle t+L. The next OPC cycle follows the handshake edge.
- With out_ready held high and run=1, throughput is one instruction per L+1 cycles.
- Outputs are registered and stable while out_valid=1 and out_ready=0. mem_addr holds, and no fetch occurs.
- redirect takes effect at the next edge; out_valid falls in the following cycle.

## Structure
- Shared package y86_pkg:
  - icode constants (HALT…POPQ)
  - stat encodings (AOK/HLT/ADR/INS)
  - RNONE=4'hF
  - fetch state enum
- Sub-module y86_ilen_decode (combinational): icode → need_regids, need_valC, instr_valid. It is reused by later decode logic.

## Test plan
- irmovq: mem[0x0e..] = 30 f9 45 00×7, pc=0x0e, run=1.
  - out_valid 10 cycles after OPC.
  - icode 3, ifun 0, rA F, rB 9, valC 0x45, valP 0x18, stat AOK.
- OPq: bytes 60 22 at 0.
  - out_valid after 2 cycles.
  - icode 6, ifun 0, rA 2, rB 2, valC 0, valP 2.
  - Next fetch at 2 after the handshake.
- Backpressure: hold out_ready=0 for 5 cycles on the previous result.
  - All outputs stable and mem_addr constant.
  - Handshake on cycle 6 advances pc to valP.
- halt byte 00 at pc=0x1d:
  - stat HLT, valP 0x1e.
  - After handshake halted=1 and mem_addr stays 0x1e indefinitely.
  - redirect to 0 clears halted and fetches.
- Invalid and out-of-range:
  - Byte C0 gives stat INS, valP pc+1.
  - pc=0x7c holding an irmovq gives stat ADR at fetch address 0x80, with valP=0x80.
- Abort:
  - redirect to 0x0b during CONST k=3 of irmovq: next output is instruction at 0x0b (61 32 → icode 6, ifun 1, rA 3, rB 2, valP 0x0d).
  - rst asserted mid-CONST clears all outputs before the next edge.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg
// Shared Y86-64 definitions used by the fetch sequencer and later decode logic:
//   - icode constants (halt .. popq)
//   - stat encodings (AOK/HLT/ADR/INS)
//   - RNONE, the register id that reads back when no register byte exists
//   - fetch_state_t, the states of the multi-cycle fetch controller
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [1:0] STAT_HLT = 2'b01;
  localparam logic [1:0] STAT_ADR = 2'b10;
  localparam logic [1:0] STAT_INS = 2'b11;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [2:0] {
    F_IDLE,
    F_OPC,
    F_REG,
    F_CONST,
    F_DONE,
    F_HALT
  } fetch_state_t;

endpackage

// File: rtl/y86_ilen_decode.sv
// y86_ilen_decode
// Combinational instruction-shape decoder.
//   icode        in   opcode nibble
//   need_regids  out  instruction carries an rA/rB byte
//   need_valc    out  instruction carries an 8-byte constant
//   instr_valid  out  icode is a defined Y86-64 opcode
module y86_ilen_decode
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic       need_regids,
  output logic       need_valc,
  output logic       instr_valid
);

  always_comb begin
    need_regids = 1'b0;
    need_valc   = 1'b0;
    instr_valid = 1'b1;
    case (icode)
      I_HALT, I_NOP, I_RET: ;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: need_regids = 1'b1;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        need_regids = 1'b1;
        need_valc   = 1'b1;
      end
      I_JXX, I_CALL: need_valc = 1'b1;
      default: instr_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/y86_fetch_sequencer.sv
// y86_fetch_sequencer
// Multi-cycle Y86-64 fetch: walks the byte-wide instruction memory one byte
// per clock from pc, assembles icode/ifun, rA/rB and valC, computes valP and
// hands the result to decode with a valid/ready handshake.
//   clk, rst             clock, asynchronous active-high reset
//   run                  permits starting a new instruction
//   redirect/redirect_pc abort the current fetch and restart at redirect_pc
//   mem_addr/mem_byte    instruction memory address and combinational data
//   out_valid/out_ready  handshake towards decode
//   icode..pc_out        assembled instruction (registered)
//   stat, halted         instruction status, sticky stop on non-AOK
module y86_fetch_sequencer
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic [63:0] mem_addr,
  input  logic [7:0]  mem_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [63:0] pc_out,
  output logic [1:0]  stat,
  output logic        halted
);

  localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);

  fetch_state_t state;
  logic [63:0]  pc;
  logic [2:0]   k;
  logic         need_reg_q;
  logic         need_valc_q;
  logic [63:0]  addr_off;
  logic         addr_err;
  logic         dec_need_reg;
  logic         dec_need_valc;
  logic         dec_valid;

  // Shape of the opcode byte currently on the bus; only consulted in OPC and
  // latched so REG/CONST know where the constant starts.
  y86_ilen_decode u_ilen (
    .icode       (mem_byte[7:4]),
    .need_regids (dec_need_reg),
    .need_valc   (dec_need_valc),
    .instr_valid (dec_valid)
  );

  // Byte offset of the current fetch from pc; outside the fetching states the
  // address rests on pc itself.
  always_comb begin
    addr_off = 64'd0;
    case (state)
      F_REG:   addr_off = 64'd1;
      F_CONST: addr_off = 64'd1 + {63'd0, need_reg_q} + {61'd0, k};
      default: addr_off = 64'd0;
    endcase
  end

  assign mem_addr = pc + addr_off;
  assign addr_err = (state == F_OPC || state == F_REG || state == F_CONST) &&
                    (mem_addr >= MEM_LIMIT);

  // Fetch state machine. Every completion path (normal or address error)
  // lands in DONE with valP already computed; the last fetched byte's address
  // plus one is valP for a clean finish, the faulting address for ADR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= F_IDLE;
      pc          <= 64'd0;
      k           <= 3'd0;
      need_reg_q  <= 1'b0;
      need_valc_q <= 1'b0;
      out_valid   <= 1'b0;
      icode       <= 4'h0;
      ifun        <= 4'h0;
      rA          <= 4'h0;
      rB          <= 4'h0;
      valC        <= 64'd0;
      valP        <= 64'd0;
      pc_out      <= 64'd0;
      stat        <= STAT_AOK;
      halted      <= 1'b0;
    end else if (redirect) begin
      // Also covers a coincident DONE handshake: decode has taken the
      // result, and the new pc simply overrides valP.
      state     <= run ? F_OPC : F_IDLE;
      pc        <= redirect_pc;
      k         <= 3'd0;
      out_valid <= 1'b0;
      icode     <= 4'h0;
      ifun      <= 4'h0;
      rA        <= 4'h0;
      rB        <= 4'h0;
      valC      <= 64'd0;
      valP      <= 64'd0;
      pc_out    <= 64'd0;
      stat      <= STAT_AOK;
      halted    <= 1'b0;
    end else begin
      case (state)
        F_IDLE: begin
          if (run) state <= F_OPC;
        end
        F_OPC: begin
          pc_out <= pc;
          valC   <= 64'd0;
          k      <= 3'd0;
          if (addr_err) begin
            icode     <= 4'h0;
            ifun      <= 4'h0;
            rA        <= 4'h0;
            rB        <= 4'h0;
            stat      <= STAT_ADR;
            valP      <= mem_addr;
            out_valid <= 1'b1;
            state     <= F_DONE;
          end else begin
            icode       <= mem_byte[7:4];
            ifun        <= mem_byte[3:0];
            need_reg_q  <= dec_need_reg;
            need_valc_q <= dec_need_valc;
            rA          <= dec_need_reg ? 4'h0 : RNONE;
            rB          <= dec_need_reg ? 4'h0 : RNONE;
            if (!dec_valid)                   stat <= STAT_INS;
            else if (mem_byte[7:4] == I_HALT) stat <= STAT_HLT;
            else                              stat <= STAT_AOK;
            if (dec_need_reg) begin
              state <= F_REG;
            end else if (dec_need_valc) begin
              state <= F_CONST;
            end else begin
              valP      <= mem_addr + 64'd1;
              out_valid <= 1'b1;
              state     <= F_DONE;
            end
          end
        end
        F_REG: begin
          if (addr_err) begin
            stat      <= STAT_ADR;
            valP      <= mem_addr;
            out_valid <= 1'b1;
            state     <= F_DONE;
          end else begin
            rA <= mem_byte[7:4];
            rB <= mem_byte[3:0];
            if (need_valc_q) begin
              state <= F_CONST;
            end else begin
              valP      <= mem_addr + 64'd1;
              out_valid <= 1'b1;
              state     <= F_DONE;
            end
          end
        end
        F_CONST: begin
          if (addr_err) begin
            stat      <= STAT_ADR;
            valP      <= mem_addr;
            out_valid <= 1'b1;
            state     <= F_DONE;
          end else begin
            valC[{k, 3'b000} +: 8] <= mem_byte;
            if (k == 3'd7) begin
              valP      <= mem_addr + 64'd1;
              out_valid <= 1'b1;
              state     <= F_DONE;
            end else begin
              k <= k + 3'd1;
            end
          end
        end
        F_DONE: begin
          if (out_ready) begin
            pc        <= valP;
            out_valid <= 1'b0;
            if (stat != STAT_AOK) begin
              halted <= 1'b1;
              state  <= F_HALT;
            end else begin
              state <= run ? F_OPC : F_IDLE;
            end
          end
        end
        F_HALT: ;
        default: state <= F_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_y86_fetch_sequencer.sv
// tb_y86_fetch_sequencer
// Self-checking bench: a behavioural memory model predicts each instruction
// starting from a redirect target; predictions go into a scoreboard queue and
// are popped and compared whenever the DUT completes a handshake.
module tb_y86_fetch_sequencer;
  import y86_pkg::*;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [63:0] pc_out;
    logic [1:0]  stat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [63:0] mem_addr;
  logic [7:0]  mem_byte;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP, pc_out;
  logic [1:0]  stat;
  logic        halted;

  logic [7:0]  mem [0:127];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  assign mem_byte = (mem_addr < 64'd128) ? mem[mem_addr[6:0]] : 8'h00;

  always #5 clk = ~clk;

  y86_fetch_sequencer #(.MEM_BYTES(128)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_addr    (mem_addr),
    .mem_byte    (mem_byte),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .icode       (icode),
    .ifun        (ifun),
    .rA          (rA),
    .rB          (rB),
    .valC        (valC),
    .valP        (valP),
    .pc_out      (pc_out),
    .stat        (stat),
    .halted      (halted)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference model: what a fetch starting at pc must produce.
  function automatic exp_t predict(input logic [63:0] pc);
    exp_t e;
    logic [63:0] a;
    logic [7:0]  b;
    bit nr, nc;
    e = '0;
    e.pc_out = pc;
    e.stat = STAT_AOK;
    if (pc >= 64'd128) begin
      e.stat = STAT_ADR;
      e.valp = pc;
      return e;
    end
    b = mem[pc[6:0]];
    e.icode = b[7:4];
    e.ifun  = b[3:0];
    case (b[7:4])
      4'h2, 4'h6, 4'hA, 4'hB: begin nr = 1; nc = 0; end
      4'h3, 4'h4, 4'h5:       begin nr = 1; nc = 1; end
      4'h7, 4'h8:             begin nr = 0; nc = 1; end
      default:                begin nr = 0; nc = 0; end
    endcase
    if (b[7:4] == 4'h0) e.stat = STAT_HLT;
    else if (b[7:4] > 4'hB) e.stat = STAT_INS;
    if (!nr) begin
      e.ra = 4'hF;
      e.rb = 4'hF;
    end
    a = pc + 64'd1;
    if (nr) begin
      if (a >= 64'd128) begin
        e.stat = STAT_ADR;
        e.valp = a;
        return e;
      end
      e.ra = mem[a[6:0]][7:4];
      e.rb = mem[a[6:0]][3:0];
      a = a + 64'd1;
    end
    if (nc) begin
      for (int i = 0; i < 8; i++) begin
        if (a >= 64'd128) begin
          e.stat = STAT_ADR;
          e.valp = a;
          return e;
        end
        e.valc[8*i +: 8] = mem[a[6:0]];
        a = a + 64'd1;
      end
    end
    e.valp = a;
    return e;
  endfunction

  // Push up to n predicted instructions, stopping after the first non-AOK one.
  task automatic pushSeq(input logic [63:0] pc, input int n);
    exp_t e;
    logic [63:0] p;
    p = pc;
    for (int i = 0; i < n; i++) begin
      e = predict(p);
      sb.push_back(e);
      if (e.stat != STAT_AOK) break;
      p = e.valp;
    end
  endtask

  // Pulse redirect for one edge and record what should come out of it.
  task automatic applyStimulus(input logic [63:0] target, input logic go, input int n);
    run = go;
    redirect = 1'b1;
    redirect_pc = target;
    pushSeq(target, n);
    @(posedge clk); #1;
    redirect = 1'b0;
  endtask

  task automatic stepCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic waitValid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic waitHalted(input string tag, input int limit);
    int c;
    c = 0;
    while (!halted && c < limit) begin
      @(posedge clk); #1;
      c++;
    end
    checkOutput(tag, 64'(halted), 64'd1);
  endtask

  task automatic loadProgram();
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h60; mem[8'h01] = 8'h22;
    mem[8'h02] = 8'h10;
    mem[8'h03] = 8'h90;
    mem[8'h04] = 8'h20; mem[8'h05] = 8'h45;
    for (int i = 8'h06; i <= 8'h0a; i++) mem[i] = 8'h10;
    mem[8'h0b] = 8'h61; mem[8'h0c] = 8'h32;
    mem[8'h0d] = 8'h10;
    mem[8'h0e] = 8'h30; mem[8'h0f] = 8'hf9; mem[8'h10] = 8'h45;
    mem[8'h18] = 8'h60; mem[8'h19] = 8'h01;
    mem[8'h1a] = 8'h10; mem[8'h1b] = 8'h10; mem[8'h1c] = 8'h10;
    mem[8'h1d] = 8'h00;
    mem[8'h30] = 8'h80;
    for (int i = 0; i < 8; i++) mem[8'h31 + i] = 8'(8'h88 - 8'h11 * i);
    mem[8'h39] = 8'hC0;
    mem[8'h40] = 8'h50; mem[8'h41] = 8'h12;
    for (int i = 0; i < 8; i++) mem[8'h42 + i] = 8'(i + 1);
    mem[8'h4a] = 8'h00;
    mem[8'h7c] = 8'h30; mem[8'h7d] = 8'hf0; mem[8'h7e] = 8'haa; mem[8'h7f] = 8'hbb;
  endtask

  // Scoreboard consumer: every accepted result must match the next prediction.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("sb_unexpected_output", 64'(out_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("icode",  64'(icode),  64'(e.icode));
        checkOutput("ifun",   64'(ifun),   64'(e.ifun));
        checkOutput("rA",     64'(rA),     64'(e.ra));
        checkOutput("rB",     64'(rB),     64'(e.rb));
        checkOutput("valC",   valC,        e.valc);
        checkOutput("valP",   valP,        e.valp);
        checkOutput("pc_out", pc_out,      e.pc_out);
        checkOutput("stat",   64'(stat),   64'(e.stat));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int lat;
    loadProgram();
    rst = 1'b1;
    run = 1'b0;
    redirect = 1'b0;
    redirect_pc = 64'd0;
    out_ready = 1'b0;
    #12;
    checkOutput("rst_mem_addr",  mem_addr,        64'd0);
    checkOutput("rst_out_valid", 64'(out_valid),  64'd0);
    checkOutput("rst_stat",      64'(stat),       64'd0);
    checkOutput("rst_halted",    64'(halted),     64'd0);
    checkOutput("rst_valP",      valP,            64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // run=0 keeps the sequencer parked in IDLE
    stepCycles(3);
    checkOutput("idle_mem_addr",  mem_addr,       64'd0);
    checkOutput("idle_out_valid", 64'(out_valid), 64'd0);

    // irmovq at 0x0e: latency, then five cycles of backpressure
    applyStimulus(64'h0e, 1'b1, 1);
    waitValid(lat);
    checkOutput("irmovq_latency", 64'(lat), 64'd10);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid",    64'(out_valid), 64'd1);
      checkOutput("bp_mem_addr", mem_addr,       64'h0e);
      checkOutput("bp_valP",     valP,           64'h18);
      checkOutput("bp_valC",     valC,           64'h45);
      stepCycles(1);
    end
    run = 1'b0;
    out_ready = 1'b1;
    stepCycles(1);
    checkOutput("adv_pc",    mem_addr,       64'h18);
    checkOutput("adv_valid", 64'(out_valid), 64'd0);

    // OPq at 0, then free-run through the program to the halt at 0x1d
    out_ready = 1'b0;
    applyStimulus(64'h00, 1'b1, 64);
    waitValid(lat);
    checkOutput("opq_latency", 64'(lat), 64'd2);
    out_ready = 1'b1;
    stepCycles(1);
    checkOutput("next_fetch_addr", mem_addr, 64'h02);
    waitHalted("halt_reached", 300);
    for (int i = 0; i < 3; i++) begin
      checkOutput("halt_mem_addr", mem_addr,       64'h1e);
      checkOutput("halt_no_valid", 64'(out_valid), 64'd0);
      stepCycles(1);
    end

    // redirect out of HALT: call then an invalid opcode
    applyStimulus(64'h30, 1'b1, 64);
    checkOutput("halt_cleared", 64'(halted), 64'd0);
    waitHalted("ins_halt", 100);

    // mrmovq followed by halt, then an irmovq that runs off the memory end
    applyStimulus(64'h40, 1'b1, 64);
    waitHalted("mrmovq_halt", 100);
    applyStimulus(64'h7c, 1'b1, 64);
    waitHalted("adr_halt", 100);
    checkOutput("adr_mem_addr", mem_addr, 64'h80);

    // abort irmovq during CONST k=3 and restart at 0x0b
    applyStimulus(64'h0e, 1'b1, 0);
    stepCycles(5);
    checkOutput("const_k3_addr", mem_addr, 64'h13);
    applyStimulus(64'h0b, 1'b1, 64);
    waitHalted("abort_halt", 300);

    // asynchronous reset in the middle of CONST
    applyStimulus(64'h0e, 1'b1, 0);
    stepCycles(4);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_mem_addr",  mem_addr,       64'd0);
    checkOutput("arst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("arst_valC",      valC,           64'd0);
    checkOutput("arst_rA",        64'(rA),        64'd0);
    checkOutput("arst_rB",        64'(rB),        64'd0);
    checkOutput("arst_icode",     64'(icode),     64'd0);
    checkOutput("arst_pc_out",    pc_out,         64'd0);
    run = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    stepCycles(2);
    checkOutput("post_rst_addr", mem_addr, 64'd0);

    checkOutput("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
